ibex_obi_bus_arbiter: RTL and testbench
=======================================

Name:
ibex_obi_bus_arbiter

Overview:
- Shares one OBI memory port between the IF-stage fetch port and the LSU data port, for single-port memory systems.
- Arbitrates requests, tracks the source of each outstanding transaction in order, and routes rvalid/rdata/err back to the issuing side.

Parameters:
MaxOutstanding, 2, maximum accepted-but-unanswered bus transactions (1..4); sets depth of the source-tracking FIFO.
DataPriority, 1'b1, 1 = data always wins a conflict; 0 = round-robin between instr and data.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
instr_req_i  in  1  fetch request
instr_addr_i  in  32  fetch address; held stable until instr_gnt_o
instr_gnt_o  out  1  fetch request accepted
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  32  fetch response data
instr_err_o  out  1  fetch response error
data_req_i  in  1  LSU request
data_we_i  in  1  LSU write enable
data_be_i  in  4  LSU byte enables
data_addr_i  in  32  LSU address
data_wdata_i  in  32  LSU write data
data_gnt_o  out  1  LSU request accepted
data_rvalid_o  out  1  LSU response valid
data_rdata_o  out  32  LSU response data
data_err_o  out  1  LSU response error
bus_req_o  out  1  shared-bus request
bus_we_o  out  1  shared-bus write enable; 0 for instr
bus_be_o  out  4  shared-bus byte enables; 4'hF for instr
bus_addr_o  out  32  shared-bus address
bus_wdata_o  out  32  shared-bus write data; 0 for instr
bus_gnt_i  in  1  shared-bus grant
bus_rvalid_i  in  1  shared-bus response valid
bus_rdata_i  in  32  shared-bus response data
bus_err_i  in  1  shared-bus response error
busy_o  out  1  FIFO non-empty or request pending

Behaviour:
- Reset: FIFO empty (count 0), no held selection, round-robin pointer = instr. All outputs 0 while rst_ni low. A transaction in flight at reset is abandoned; a later rvalid is dropped.
- Selection: if count == MaxOutstanding, bus_req_o = 0 and both gnt_o = 0. A same-cycle bus_rvalid_i does not free the slot; there is no combinational rvalid->req path. Otherwise the winner is chosen by DataPriority/round-robin; bus_req_o = winner's req; bus_we/be/addr/wdata are muxed from the winner.
- Hold: if bus_req_o = 1 and bus_gnt_i = 0, the selection is registered and held until granted, even if the other side requests. This keeps the OBI address stable.
- Grant: winner's gnt_o = bus_gnt_i & bus_req_o; the loser's gnt_o = 0. A grant pushes the source id (0 = instr, 1 = data) into the FIFO and releases the hold. In round-robin mode, the pointer moves to the other side.
- Response: rvalid is combinational with zero latency. {instr,data}_rvalid_o = bus_rvalid_i & FIFO head id match; rdata/err pass through to both sides. rvalid pops the head.
- Simultaneous push and pop: count is unchanged; the wr/rd pointers wrap modulo MaxOutstanding.
- bus_rvalid_i with an empty FIFO is ignored, and no pointer moves. Assertion: no rvalid when empty.
- busy_o = (count != 0) | instr_req_i | data_req_i.

Test Plan:
- Instr-only, gnt tied 1, rvalid one cycle later, rdata 0x00000013 -> instr_gnt_o each cycle, instr_rvalid_o with 0x00000013, data_rvalid_o = 0.
- Both req in the same cycle, DataPriority=1 -> data granted first (bus_we/addr from LSU), instr granted next cycle. Responses return to data then instr, in order.
- DataPriority=0, both req continuously -> grants alternate instr, data, instr, data; each response is routed to the issuer.
- bus_gnt_i held 0 for 3 cycles with instr selected; data_req_i rises at cycle 1 -> bus_addr_o stays at the instr address and the instr grant comes first.
- MaxOutstanding=2, two grants, no rvalid -> bus_req_o = 0. On rvalid (err=1, head = instr) -> instr_err_o = 1, and bus_req_o reasserts the next cycle.
- rst_ni pulsed low with 2 outstanding, then stray bus_rvalid_i -> no *_rvalid_o, busy_o = 0 with reqs low.

Source files
------------

// File: rtl/ibex_obi_bus_arbiter.sv
// ibex_obi_bus_arbiter: shares one OBI port between instruction fetch and LSU,
// routing in-order responses back to the side that issued each transaction.
module ibex_obi_bus_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataPriority   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        busy_o
);
  localparam int unsigned PtrW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  typedef logic [PtrW-1:0] ptr_t;
  localparam ptr_t LastPtr = ptr_t'(MaxOutstanding - 1);

  logic [MaxOutstanding-1:0] ids_q;
  ptr_t                      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]           count_q;
  logic                      hold_q, hold_sel_q, rr_q, granted_q;
  logic                      full, sel, req, gnt, pop, head;

  // sel: 0 = instr, 1 = data; a pending ungranted request keeps its side
  assign full = count_q == CntW'(MaxOutstanding);
  assign sel  = hold_q ? hold_sel_q :
                (instr_req_i & data_req_i) ? (DataPriority | rr_q) : data_req_i;
  assign req  = rst_ni & ~full & (sel ? data_req_i : instr_req_i);
  assign gnt  = req & bus_gnt_i;
  assign head = ids_q[rd_ptr_q];
  assign pop  = rst_ni & bus_rvalid_i & (count_q != '0);

  assign bus_req_o      = req;
  assign bus_we_o       = rst_ni & sel & data_we_i;
  assign bus_be_o       = ~rst_ni ? 4'h0 : sel ? data_be_i : 4'hF;
  assign bus_addr_o     = ~rst_ni ? '0 : sel ? data_addr_i : instr_addr_i;
  assign bus_wdata_o    = (rst_ni & sel) ? data_wdata_i : '0;
  assign instr_gnt_o    = gnt & ~sel;
  assign data_gnt_o     = gnt & sel;
  assign instr_rvalid_o = pop & ~head;
  assign data_rvalid_o  = pop & head;
  assign instr_rdata_o  = rst_ni ? bus_rdata_i : '0;
  assign data_rdata_o   = rst_ni ? bus_rdata_i : '0;
  assign instr_err_o    = rst_ni & bus_err_i;
  assign data_err_o     = rst_ni & bus_err_i;
  assign busy_o         = rst_ni & ((count_q != '0) | instr_req_i | data_req_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ids_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= 1'b0;
      hold_sel_q <= 1'b0;
      rr_q       <= 1'b0;
      granted_q  <= 1'b0;
    end else begin
      if (gnt) begin
        ids_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= wr_ptr_q == LastPtr ? '0 : wr_ptr_q + 1'b1;
        granted_q       <= 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q == LastPtr ? '0 : rd_ptr_q + 1'b1;
      count_q    <= count_q + CntW'(gnt) - CntW'(pop);
      hold_q     <= req & ~bus_gnt_i;
      hold_sel_q <= sel;
      if (gnt && !DataPriority) rr_q <= ~sel;
    end
  end

  // responses to transactions abandoned by reset arrive before any new grant
  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni || !granted_q)
    !(bus_rvalid_i && count_q == '0)) else $warning("rvalid with no outstanding transaction");
endmodule

// File: tb/tb_ibex_obi_bus_arbiter.sv
// tb_ibex_obi_bus_arbiter: directed vectors for data-priority and round-robin arbiters.
module tb_ibex_obi_bus_arbiter;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic ir, dr, dwe, g, rv, err;
  logic [3:0] dbe;
  logic [31:0] iaddr, daddr, dwdata, rd;
  logic a_ig, a_irv, a_ierr, a_dg, a_drv, a_derr, a_br, a_bwe, a_busy;
  logic b_ig, b_irv, b_ierr, b_dg, b_drv, b_derr, b_br, b_bwe, b_busy;
  logic [31:0] a_ird, a_drd, a_baddr, a_bwd, b_ird, b_drd, b_baddr, b_bwd;
  logic [3:0] a_bbe, b_bbe;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  ibex_obi_bus_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) u_dp (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(ir), .instr_addr_i(iaddr), .instr_gnt_o(a_ig), .instr_rvalid_o(a_irv),
    .instr_rdata_o(a_ird), .instr_err_o(a_ierr),
    .data_req_i(dr), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(daddr), .data_wdata_i(dwdata),
    .data_gnt_o(a_dg), .data_rvalid_o(a_drv), .data_rdata_o(a_drd), .data_err_o(a_derr),
    .bus_req_o(a_br), .bus_we_o(a_bwe), .bus_be_o(a_bbe), .bus_addr_o(a_baddr), .bus_wdata_o(a_bwd),
    .bus_gnt_i(g), .bus_rvalid_i(rv), .bus_rdata_i(rd), .bus_err_i(err), .busy_o(a_busy));

  ibex_obi_bus_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_rr (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(ir), .instr_addr_i(iaddr), .instr_gnt_o(b_ig), .instr_rvalid_o(b_irv),
    .instr_rdata_o(b_ird), .instr_err_o(b_ierr),
    .data_req_i(dr), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(daddr), .data_wdata_i(dwdata),
    .data_gnt_o(b_dg), .data_rvalid_o(b_drv), .data_rdata_o(b_drd), .data_err_o(b_derr),
    .bus_req_o(b_br), .bus_we_o(b_bwe), .bus_be_o(b_bbe), .bus_addr_o(b_baddr), .bus_wdata_o(b_bwd),
    .bus_gnt_i(g), .bus_rvalid_i(rv), .bus_rdata_i(rd), .bus_err_i(err), .busy_o(b_busy));

  typedef struct {
    logic ir, dr, g, rv, err;
    logic [31:0] rd;
    logic eig, edg, ebr, eirv, edrv, eerr;
    logic [31:0] eaddr;
    logic ewe;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic i, input logic d, input logic gg, input logic r,
                       input logic e, input logic [31:0] dat);
    ir = i; dr = d; g = gg; rv = r; err = e; rd = dat;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, " bus_req"}, a_br, 0);
    chk({tag, " gnts"}, {a_ig, a_dg}, 0);
    chk({tag, " rvalids"}, {a_irv, a_drv}, 0);
    chk({tag, " busy"}, a_busy, 0);
    chk({tag, " addr"}, a_baddr, 0);
    chk({tag, " rdata"}, a_ird | a_drd, 0);
    chk({tag, " err"}, {a_ierr, a_derr}, 0);
  endtask

  vec_t tbl[16];

  initial begin
    iaddr = 32'h100; daddr = 32'h200; dwe = 1'b1; dbe = 4'h3; dwdata = 32'hdead_beef;
    // ir dr g rv err rd | ig dg br irv drv err addr we
    tbl[0]  = '{1, 0, 1, 0, 0, 32'h0,  1, 0, 1, 0, 0, 0, 32'h100, 0};
    tbl[1]  = '{1, 0, 1, 1, 0, 32'h13, 1, 0, 1, 1, 0, 0, 32'h100, 0};
    tbl[2]  = '{0, 0, 0, 1, 0, 32'h13, 0, 0, 0, 1, 0, 0, 32'h100, 0};
    tbl[3]  = '{1, 1, 1, 0, 0, 32'h0,  0, 1, 1, 0, 0, 0, 32'h200, 1};
    tbl[4]  = '{1, 0, 1, 0, 0, 32'h0,  1, 0, 1, 0, 0, 0, 32'h100, 0};
    tbl[5]  = '{1, 0, 1, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h100, 0};
    tbl[6]  = '{1, 0, 1, 1, 1, 32'h55, 0, 0, 0, 0, 1, 1, 32'h100, 0};
    tbl[7]  = '{1, 0, 1, 1, 1, 32'h66, 1, 0, 1, 1, 0, 1, 32'h100, 0};
    tbl[8]  = '{0, 0, 0, 1, 0, 32'h77, 0, 0, 0, 1, 0, 0, 32'h100, 0};
    // instr stalled by gnt=0 while data starts requesting: address must hold
    tbl[9]  = '{1, 0, 0, 0, 0, 32'h0,  0, 0, 1, 0, 0, 0, 32'h100, 0};
    tbl[10] = '{1, 1, 0, 0, 0, 32'h0,  0, 0, 1, 0, 0, 0, 32'h100, 0};
    tbl[11] = '{1, 1, 0, 0, 0, 32'h0,  0, 0, 1, 0, 0, 0, 32'h100, 0};
    tbl[12] = '{1, 1, 1, 0, 0, 32'h0,  1, 0, 1, 0, 0, 0, 32'h100, 0};
    tbl[13] = '{0, 1, 1, 0, 0, 32'h0,  0, 1, 1, 0, 0, 0, 32'h200, 1};
    tbl[14] = '{0, 0, 0, 1, 0, 32'h88, 0, 0, 0, 1, 0, 0, 32'h100, 0};
    tbl[15] = '{0, 0, 0, 1, 0, 32'h99, 0, 0, 0, 0, 1, 0, 32'h100, 0};

    drive(1, 1, 1, 1, 1, 32'hffff_ffff);
    repeat (2) @(negedge clk);
    chk_zero_a("reset");
    drive(0, 0, 0, 0, 0, 0);
    rst_ni = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].ir, tbl[i].dr, tbl[i].g, tbl[i].rv, tbl[i].err, tbl[i].rd);
      #1;
      chk($sformatf("v%0d instr_gnt", i), a_ig, tbl[i].eig);
      chk($sformatf("v%0d data_gnt", i), a_dg, tbl[i].edg);
      chk($sformatf("v%0d bus_req", i), a_br, tbl[i].ebr);
      chk($sformatf("v%0d instr_rvalid", i), a_irv, tbl[i].eirv);
      chk($sformatf("v%0d data_rvalid", i), a_drv, tbl[i].edrv);
      chk($sformatf("v%0d errs", i), {a_ierr, a_derr}, {2{tbl[i].eerr}});
      chk($sformatf("v%0d rdata", i), {a_ird ^ a_drd, a_ird}, {32'h0, tbl[i].rd});
      chk($sformatf("v%0d bus_addr", i), a_baddr, tbl[i].eaddr);
      chk($sformatf("v%0d bus_we", i), a_bwe, tbl[i].ewe);
      chk($sformatf("v%0d bus_be", i), a_bbe, tbl[i].ewe ? 4'h3 : 4'hF);
      chk($sformatf("v%0d bus_wdata", i), a_bwd, tbl[i].ewe ? 32'hdead_beef : 32'h0);
    end

    @(negedge clk);
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    // round-robin: grants alternate, each response follows the previous grant
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(1, 1, 1, k > 0, 0, 32'h1000 + k);
      #1;
      chk($sformatf("rr%0d instr_gnt", k), b_ig, k % 2 == 0);
      chk($sformatf("rr%0d data_gnt", k), b_dg, k % 2 == 1);
      chk($sformatf("rr%0d bus_addr", k), b_baddr, k % 2 ? 32'h200 : 32'h100);
      chk($sformatf("rr%0d instr_rvalid", k), b_irv, k > 0 && (k - 1) % 2 == 0);
      chk($sformatf("rr%0d data_rvalid", k), b_drv, k > 0 && (k - 1) % 2 == 1);
      chk($sformatf("rr%0d dp data_gnt", k), {a_dg, a_ig}, 2'b10);
    end

    // fill to two outstanding, then reset and send a stray response
    @(negedge clk);
    drive(1, 0, 1, 0, 0, 0);
    #1;
    chk("pre-reset instr_gnt", a_ig, 1);
    @(negedge clk);
    #1;
    chk("pre-reset full", a_br, 0);
    rst_ni = 1'b0;
    drive(1, 1, 1, 1, 1, 32'h1234_5678);
    #1;
    chk_zero_a("mid-reset");
    @(negedge clk);
    rst_ni = 1'b1;
    drive(0, 0, 0, 1, 0, 32'h4321);
    #1;
    chk("stray rvalids dp", {a_irv, a_drv}, 0);
    chk("stray rvalids rr", {b_irv, b_drv}, 0);
    chk("post-reset busy", {a_busy, b_busy}, 0);
    @(negedge clk);
    drive(1, 0, 1, 0, 0, 0);
    #1;
    chk("post-reset instr_gnt", a_ig, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("post-reset busy outstanding", a_busy, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
